// File: rtl/enemy_spawn_if.sv
// Bus between the enemy spawn scheduler and its environment (collision, tank bots, game FSM).
// Signal names keep the _i/_o suffixes seen from the scheduler's side.
interface enemy_spawn_if #(
    parameter int NUM_ENEMIES = 2
);
    logic                   enable_i;
    logic                   one_sec_clk_i;
    logic [NUM_ENEMIES-1:0] enemy_die_i;
    logic                   spawn_blocked_i;
    logic [NUM_ENEMIES-1:0] enemy_revive_o;
    logic [NUM_ENEMIES-1:0] enemy_alive_o;
    logic [9:0]             spawn_x_o;
    logic [9:0]             spawn_y_o;
    logic [5:0]             reserve_o;
    logic [5:0]             kills_o;
    logic                   all_cleared_o;

    modport slave (
        input  enable_i, one_sec_clk_i, enemy_die_i, spawn_blocked_i,
        output enemy_revive_o, enemy_alive_o, spawn_x_o, spawn_y_o,
        reserve_o, kills_o, all_cleared_o
    );

    modport master (
        output enable_i, one_sec_clk_i, enemy_die_i, spawn_blocked_i,
        input  enemy_revive_o, enemy_alive_o, spawn_x_o, spawn_y_o,
        reserve_o, kills_o, all_cleared_o
    );
endinterface

// File: rtl/enemy_spawn_ctrl.sv
// Enemy respawn scheduler: per-slot life FSM with second-tick delay counters,
// round-robin grant of READY slots onto rotating spawn points from a finite reserve.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_WAIT  | dead or freshly reset, counting seconds down to READY
// ST_READY | delay elapsed, waiting for a spawn grant
// ST_ALIVE | on screen, a die pulse sends it back to ST_WAIT
// ST_DONE  | reserve exhausted, terminal until reset
module enemy_spawn_ctrl #(
    parameter int          NUM_ENEMIES       = 2,
    parameter int          TOTAL_ENEMIES     = 20,
    parameter int          RESPAWN_DELAY_SEC = 3,
    parameter int          INIT_DELAY_SEC    = 1,
    parameter logic [9:0]  SPAWN_X0          = 10'd32,
    parameter logic [9:0]  SPAWN_X1          = 10'd224,
    parameter logic [9:0]  SPAWN_X2          = 10'd416,
    parameter logic [9:0]  SPAWN_Y           = 10'd32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    enemy_spawn_if.slave  bus
);
    localparam int PW = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;

    localparam logic [1:0] ST_WAIT  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
    localparam logic [1:0] ST_ALIVE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]             slot_state [NUM_ENEMIES];
    logic [3:0]             slot_cnt   [NUM_ENEMIES];
    logic [1:0]             state_nxt  [NUM_ENEMIES];
    logic [3:0]             cnt_nxt    [NUM_ENEMIES];

    logic                   tick_prev;
    logic                   tick;
    logic                   grant_q;
    logic                   grant;
    logic                   found;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          winner;
    logic [PW:0]            cand;
    logic [1:0]             sp_idx;
    logic [5:0]             reserve_q;
    logic [5:0]             reserve_nxt;
    logic [5:0]             kills_q;
    logic [5:0]             kills_nxt;
    logic [6:0]             kills_sum;
    logic [NUM_ENEMIES-1:0] ready_vec;
    logic [NUM_ENEMIES-1:0] die_ok;
    logic [NUM_ENEMIES-1:0] alive_nxt;
    logic [NUM_ENEMIES-1:0] revive_nxt;
    logic [NUM_ENEMIES-1:0] revive_q;
    logic [NUM_ENEMIES-1:0] alive_q;
    logic [9:0]             spawn_x_q;
    logic [9:0]             spawn_pt;
    logic                   all_cleared_q;

    // Rising edge of the second square wave; ignored entirely while paused.
    always_comb tick = bus.enable_i & bus.one_sec_clk_i & ~tick_prev;

    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            ready_vec[i] = (slot_state[i] == ST_READY);
        end
    end

    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_ENEMIES; k++) begin
            cand = (PW+1)'(rr_ptr) + (PW+1)'(k);
            if (cand >= (PW+1)'(NUM_ENEMIES)) begin
                cand = cand - (PW+1)'(NUM_ENEMIES);
            end
            if (!found && ready_vec[cand[PW-1:0]]) begin
                winner = cand[PW-1:0];
                found  = 1'b1;
            end
        end
    end

    // The one-cycle gap after a grant lets the new tank raise spawn_blocked.
    always_comb begin
        grant = bus.enable_i & ~bus.spawn_blocked_i & (reserve_q != 6'd0)
              & found & ~grant_q;
    end

    always_comb begin
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            state_nxt[i] = slot_state[i];
            cnt_nxt[i]   = slot_cnt[i];
            die_ok[i]    = 1'b0;
            case (slot_state[i])
                ST_WAIT: begin
                    if (tick) begin
                        if (slot_cnt[i] == 4'd1) begin
                            state_nxt[i] = (reserve_q != 6'd0) ? ST_READY : ST_DONE;
                        end else begin
                            cnt_nxt[i] = slot_cnt[i] - 4'd1;
                        end
                    end
                end
                ST_READY: begin
                    if (grant && (winner == PW'(i))) begin
                        state_nxt[i] = ST_ALIVE;
                    end else if (reserve_q == 6'd0) begin
                        state_nxt[i] = ST_DONE;
                    end
                end
                ST_ALIVE: begin
                    if (bus.enemy_die_i[i]) begin
                        state_nxt[i] = ST_WAIT;
                        cnt_nxt[i]   = 4'(RESPAWN_DELAY_SEC);
                        die_ok[i]    = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        kills_sum = {1'b0, kills_q};
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            kills_sum = kills_sum + {6'd0, die_ok[i]};
        end
        kills_nxt = (kills_sum > 7'd63) ? 6'd63 : kills_sum[5:0];
    end

    always_comb begin
        revive_nxt = '0;
        for (int i = 0; i < NUM_ENEMIES; i++) begin
            alive_nxt[i] = (state_nxt[i] == ST_ALIVE);
            if (grant && (winner == PW'(i))) begin
                revive_nxt[i] = 1'b1;
            end
        end
        reserve_nxt = grant ? (reserve_q - 6'd1) : reserve_q;
    end

    always_comb begin
        case (sp_idx)
            2'd0:    spawn_pt = SPAWN_X0;
            2'd1:    spawn_pt = SPAWN_X1;
            default: spawn_pt = SPAWN_X2;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                slot_state[i] <= ST_WAIT;
                slot_cnt[i]   <= 4'(INIT_DELAY_SEC);
            end
            tick_prev     <= 1'b1;
            grant_q       <= 1'b0;
            rr_ptr        <= '0;
            sp_idx        <= 2'd0;
            reserve_q     <= 6'(TOTAL_ENEMIES);
            kills_q       <= 6'd0;
            revive_q      <= '0;
            alive_q       <= '0;
            spawn_x_q     <= SPAWN_X0;
            all_cleared_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENEMIES; i++) begin
                slot_state[i] <= state_nxt[i];
                slot_cnt[i]   <= cnt_nxt[i];
            end
            tick_prev <= bus.one_sec_clk_i;
            grant_q   <= grant;
            revive_q  <= revive_nxt;
            alive_q   <= alive_nxt;
            reserve_q <= reserve_nxt;
            kills_q   <= kills_nxt;
            if (grant) begin
                spawn_x_q <= spawn_pt;
                sp_idx    <= (sp_idx == 2'd2) ? 2'd0 : sp_idx + 2'd1;
                rr_ptr    <= (winner == PW'(NUM_ENEMIES - 1)) ? '0 : winner + PW'(1);
            end
            // Sticky: once the reserve is gone and nobody is on screen the round is over.
            all_cleared_q <= all_cleared_q | ((reserve_nxt == 6'd0) & ~|alive_nxt);
        end
    end

    assign bus.enemy_revive_o = revive_q;
    assign bus.enemy_alive_o  = alive_q;
    assign bus.spawn_x_o      = spawn_x_q;
    assign bus.spawn_y_o      = SPAWN_Y;
    assign bus.reserve_o      = reserve_q;
    assign bus.kills_o        = kills_q;
    assign bus.all_cleared_o  = all_cleared_q;
endmodule

// File: doc/enemy_spawn_ctrl.md
Name: enemy_spawn_ctrl

Overview:
Schedules respawn of the bot tanks from a finite enemy reserve. Tracks each enemy slot's life state and runs a per-slot respawn delay off the one-second tick. Arbitrates READY slots round-robin onto rotating spawn points, one grant at a time, and issues the revive pulse and spawn coordinates that the tank_bot instances consume. Sits between bullet_collide (die pulses) and the enemy tank_bot instances, gated by the game FSM's playing state.

Parameters:
NUM_ENEMIES, 2, number of on-screen enemy slots (1..8)
TOTAL_ENEMIES, 20, enemies in the reserve per round (1..63)
RESPAWN_DELAY_SEC, 3, seconds from death to READY (1..15)
INIT_DELAY_SEC, 1, seconds from reset to first READY for every slot (1..15)
SPAWN_X0 / SPAWN_X1 / SPAWN_X2, 10'd32 / 10'd224 / 10'd416, spawn point x coordinates
SPAWN_Y, 10'd32, common spawn y coordinate

Ports:
clk_i  in  1  VGA pixel clock; all logic on the rising edge
reset_i  in  1  synchronous, active-high reset
enable_i  in  1  game is playing; low freezes timers and grants
one_sec_clk_i  in  1  one-second square wave, synchronous to clk_i; only its rising edges count
enemy_die_i  in  NUM_ENEMIES  one-cycle die pulse per slot
spawn_blocked_i  in  1  spawn area occupied by a tank box; inhibits grants
enemy_revive_o  out  NUM_ENEMIES  one-cycle revive pulse to the granted slot
enemy_alive_o  out  NUM_ENEMIES  slot is in ALIVE
spawn_x_o  out  10  x of the current grant, held until the next grant
spawn_y_o  out  10  SPAWN_Y, valid with the revive pulse
reserve_o  out  6  enemies not yet spawned
kills_o  out  6  die pulses accepted since reset
all_cleared_o  out  1  reserve empty and no slot ALIVE

Behaviour:
- Reset, all synchronous: every slot goes to WAIT with its counter = INIT_DELAY_SEC. reserve_o = TOTAL_ENEMIES, kills_o = 0, enemy_revive_o = 0, enemy_alive_o = 0, spawn_x_o = SPAWN_X0, spawn_y_o = SPAWN_Y, spawn-point index = 0, round-robin pointer = 0, all_cleared_o = 0. The tick-edge register resets to 1, so no tick is counted in the first cycle after reset. Reset asserted mid-operation aborts any pending grant in the same cycle.
- Tick: tick = one_sec_clk_i & ~prev. It is evaluated only while enable_i = 1; otherwise it is discarded and not remembered.
- Per-slot states and transitions:
  - WAIT: on a tick, the counter decrements. When the counter is 1 on a tick, the slot goes to READY if reserve_o > 0, else to DONE.
  - READY: waits for a grant. If reserve_o reaches 0 while READY, the slot goes to DONE in the next cycle.
  - ALIVE: on enemy_die_i[i], kills_o increments (saturates at 63) and the slot goes to WAIT with counter = RESPAWN_DELAY_SEC. A die pulse in any other state is ignored and does not count.
  - DONE: terminal until reset.
- Grant, evaluated each cycle. A grant requires all of: enable_i = 1, spawn_blocked_i = 0, reserve_o > 0, at least one READY slot, and no grant in the previous cycle (one-cycle gap so the new tank box can assert spawn_blocked_i).
  - Arbitration is round-robin starting at the pointer; the pointer moves to winner+1 (mod NUM_ENEMIES).
  - The winner goes to ALIVE in the next cycle.
  - enemy_revive_o[winner] is a registered one-cycle pulse in that same next cycle. spawn_x_o is updated to the spawn point at the current index in that cycle.
  - The spawn-point index advances 0 -> 1 -> 2 -> 0. reserve_o decrements by 1.
  - Latency from eligibility to pulse is one cycle.
- enemy_alive_o is the registered state == ALIVE; it rises in the same cycle as the revive pulse.
- Simultaneous die on slot A and grant to slot B in one cycle: both are applied.
- all_cleared_o is registered: (reserve_o == 0) & no ALIVE slot. It stays high until reset.
- Widths: counters are 4 bits. reserve_o and kills_o are 6 bits, zero-extended from the parameter values.

Test Plan:
- Defaults, enable_i=1, spawn_blocked_i=0, 1-s tick every 8 cycles: first tick -> slot0 revive pulse with spawn_x_o=32; two cycles later slot1 revive with spawn_x_o=224; reserve_o=18.
- Die pulse on slot0 while ALIVE -> kills_o=1, enemy_alive_o[0]=0; no revive until the 3rd subsequent tick; that revive has spawn_x_o=416 and reserve_o=17.
- spawn_blocked_i=1 while both slots are READY for 100 cycles -> no revive pulses; release -> slot0 pulse, one idle cycle, then slot1 pulse.
- enable_i=0 across 5 ticks with slot in WAIT (counter 3) -> counter stays 3; re-enable -> READY after 3 more ticks.
- TOTAL_ENEMIES=3, kill every enemy as it spawns -> exactly 3 revive pulses, kills_o=3, reserve_o=0; all_cleared_o=1 one cycle after the last die; both slots end in DONE.
- Reset asserted in the cycle a grant is eligible -> no revive pulse; all outputs return to their reset values next cycle; extra die pulses to non-ALIVE slots leave kills_o=0.
